// File: rtl/sha_pkg.sv
// Shared SHA-256 core state encodings, bus widths and the sequencer's internal FSM states.
// The SHA core decodes its state input with the same ST_* values.
package sha_pkg;

    localparam int CHUNK_W = 512;
    localparam int HASH_W  = 256;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd2,
        ST_GAP   = 3'd3,
        ST_LOAD  = 3'd4,
        ST_COMP  = 3'd5,
        ST_FINAL = 3'd6,
        ST_CAPT  = 3'd7
    } core_state_e;

    // SETTLE and WAIT both present ST_GAP to the core but behave differently here.
    typedef enum logic [3:0] {
        S_IDLE,
        S_INIT,
        S_LOAD,
        S_COMP,
        S_SETTLE,
        S_WAIT,
        S_FINAL,
        S_CAPT
    } seq_state_e;

    function automatic core_state_e core_code(input seq_state_e s);
        case (s)
            S_INIT:   return ST_INIT;
            S_LOAD:   return ST_LOAD;
            S_COMP:   return ST_COMP;
            S_SETTLE: return ST_GAP;
            S_WAIT:   return ST_GAP;
            S_FINAL:  return ST_FINAL;
            S_CAPT:   return ST_CAPT;
            default:  return ST_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/sha256_sequencer.sv
// Control sequencer for the SHA-256 core: streams pre-padded chunks into the core,
// walks it through init/load/compress/final, and captures the digest with a valid pulse.
module sha256_sequencer
    import sha_pkg::*;
#(
    parameter int SETTLE_CYCLES = 0,
    parameter int CNT_W         = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [CHUNK_W-1:0] chunk_data,
    input  logic               chunk_valid,
    input  logic               chunk_last,
    output logic               chunk_ready,
    output logic [2:0]         core_state,
    output logic [CHUNK_W-1:0] core_chunk,
    input  logic [HASH_W-1:0]  core_hash,
    output logic [HASH_W-1:0]  hash_out,
    output logic               hash_valid,
    output logic               busy,
    output logic [CNT_W-1:0]   chunk_count
);

    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SET_W-1:0] SETTLE_LOAD =
        SET_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

    seq_state_e         state_q, state_d;
    logic [CHUNK_W-1:0] chunk_q;
    logic               last_q;
    logic [CNT_W-1:0]   count_q;
    logic [SET_W-1:0]   settle_q;
    logic [HASH_W-1:0]  hash_q;
    logic               hash_valid_q;
    logic               accept;

    assign accept = chunk_valid && chunk_ready;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (accept) state_d = S_INIT;
            S_INIT:   state_d = S_LOAD;
            S_LOAD:   state_d = S_COMP;
            S_COMP: begin
                if (SETTLE_CYCLES > 0) state_d = S_SETTLE;
                else if (last_q)       state_d = S_FINAL;
                else                   state_d = S_WAIT;
            end
            S_SETTLE: begin
                if (settle_q == '0) state_d = last_q ? S_FINAL : S_WAIT;
            end
            S_WAIT:   if (accept) state_d = S_LOAD;
            S_FINAL:  state_d = S_CAPT;
            S_CAPT:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Ready is a pure function of state and reset so the upstream never sees a combinational loop.
    always_comb begin
        chunk_ready = reset && ((state_q == S_IDLE) || (state_q == S_WAIT));
        core_state  = core_code(state_q);
        busy        = (state_q != S_IDLE);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            chunk_q      <= '0;
            last_q       <= 1'b0;
            count_q      <= '0;
            settle_q     <= '0;
            hash_q       <= '0;
            hash_valid_q <= 1'b0;
        end else begin
            hash_valid_q <= 1'b0;
            if (accept) begin
                chunk_q <= chunk_data;
                last_q  <= chunk_last;
            end
            if ((state_q == S_IDLE) && accept) begin
                count_q <= '0;
            end else if (state_q == S_COMP) begin
                count_q <= count_q + CNT_W'(1);
            end
            if (state_q == S_COMP) begin
                settle_q <= SETTLE_LOAD;
            end else if ((state_q == S_SETTLE) && (settle_q != '0)) begin
                settle_q <= settle_q - SET_W'(1);
            end
            if (state_q == S_CAPT) begin
                hash_q       <= core_hash;
                hash_valid_q <= 1'b1;
            end
        end
    end

    assign core_chunk  = chunk_q;
    assign hash_out    = hash_q;
    assign hash_valid  = hash_valid_q;
    assign chunk_count = count_q;

endmodule

// File: tb/tb_sha256_sequencer.sv
// Bench for sha256_sequencer: two instances (SETTLE_CYCLES 0 and 3), each driving a
// behavioural SHA-256 core, checked against known digests and a chained-compress reference.
module tb_sha256_sequencer;

    localparam logic [255:0] IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                   32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    localparam logic [511:0] ABC_BLK = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] TWO_BLK0 = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                         32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                         32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                         32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] TWO_BLK1 = {480'h0, 32'h000001c0};
    localparam logic [255:0] ABC_DIGEST = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] TWO_DIGEST = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha_compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0] w [0:63];
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
        for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0 = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
            s1 = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = w[i-16] + s0 + w[i-7] + s1;
        end
        {a, b, c, d, e, f, g, h} = hin;
        for (int i = 0; i < 64; i++) begin
            t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
            t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
                hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + h};
    endfunction

    function automatic logic [511:0] rand512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom();
        return r;
    endfunction

    logic         clock = 1'b0;
    logic         reset;
    logic [511:0] d0, d1;
    logic         v0, v1, l0, l1;
    logic         chunk_ready0, chunk_ready1, hash_valid0, hash_valid1, busy0, busy1;
    logic [2:0]   core_state0, core_state1;
    logic [511:0] core_chunk0, core_chunk1;
    logic [255:0] core_hash0, core_hash1, hash_out0, hash_out1;
    logic [15:0]  chunk_count0, chunk_count1;

    always #5 clock = ~clock;

    sha256_sequencer #(.SETTLE_CYCLES(0), .CNT_W(16)) u0 (
        .clock(clock), .reset(reset), .chunk_data(d0), .chunk_valid(v0), .chunk_last(l0),
        .chunk_ready(chunk_ready0), .core_state(core_state0), .core_chunk(core_chunk0),
        .core_hash(core_hash0), .hash_out(hash_out0), .hash_valid(hash_valid0),
        .busy(busy0), .chunk_count(chunk_count0));

    sha256_sequencer #(.SETTLE_CYCLES(3), .CNT_W(16)) u1 (
        .clock(clock), .reset(reset), .chunk_data(d1), .chunk_valid(v1), .chunk_last(l1),
        .chunk_ready(chunk_ready1), .core_state(core_state1), .core_chunk(core_chunk1),
        .core_hash(core_hash1), .hash_out(hash_out1), .hash_valid(hash_valid1),
        .busy(busy1), .chunk_count(chunk_count1));

    // Behavioural SHA-256 cores: init loads IV, load latches the chunk, compress chains, final publishes.
    logic [255:0] c0_h, c1_h;
    logic [511:0] c0_blk, c1_blk;

    always @(posedge clock) begin
        if (!reset) begin
            c0_h <= '0; c0_blk <= '0; core_hash0 <= '0;
        end else begin
            case (core_state0)
                3'd2: c0_h <= IV;
                3'd4: c0_blk <= core_chunk0;
                3'd5: c0_h <= sha_compress(c0_h, c0_blk);
                3'd6: core_hash0 <= c0_h;
                default: ;
            endcase
        end
    end

    always @(posedge clock) begin
        if (!reset) begin
            c1_h <= '0; c1_blk <= '0; core_hash1 <= '0;
        end else begin
            case (core_state1)
                3'd2: c1_h <= IV;
                3'd4: c1_blk <= core_chunk1;
                3'd5: c1_h <= sha_compress(c1_h, c1_blk);
                3'd6: core_hash1 <= c1_h;
                default: ;
            endcase
        end
    end

    int           checks = 0;
    int           errors = 0;
    logic [2:0]   trace0[$];
    logic [2:0]   trace1[$];
    logic [2:0]   prev0 = 3'd0;
    logic [2:0]   prev1 = 3'd0;
    logic [511:0] msgq[$];
    int           gapq[$];

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: advance to the next falling edge and check the per-cycle rules.
    task automatic tick();
        @(negedge clock);
        trace0.push_back(core_state0);
        trace1.push_back(core_state1);
        chk("ready0", chunk_ready0, reset && (core_state0 == 3'd0 || core_state0 == 3'd3));
        chk("busy0", busy0, core_state0 != 3'd0);
        chk("hv_pulse0", hash_valid0, prev0 == 3'd7);
        chk("busy1", busy1, core_state1 != 3'd0);
        chk("hv_pulse1", hash_valid1, prev1 == 3'd7);
        prev0 = core_state0;
        prev1 = core_state1;
    endtask

    // Sends msgq through u0 with WAIT gaps from gapq, junk on chunk_valid whenever not ready.
    task automatic run_msg(input string tag);
        logic [255:0] ref_h;
        logic [2:0]   expq[$];
        int           n, idx, cur, waitc, lat;
        bit           acc, done;
        n = msgq.size();
        ref_h = IV;
        foreach (msgq[i]) ref_h = sha_compress(ref_h, msgq[i]);
        expq = {3'd2, 3'd4, 3'd5};
        for (int i = 1; i < n; i++) begin
            repeat (gapq[i] + 1) expq.push_back(3'd3);
            expq.push_back(3'd4);
            expq.push_back(3'd5);
        end
        expq.push_back(3'd6); expq.push_back(3'd7); expq.push_back(3'd0);
        idx = 0; cur = -1; waitc = 0; lat = 0; done = 0;
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            acc = 0;
            if (chunk_ready0) begin
                if (idx < n && waitc == 0) begin
                    d0 = msgq[idx]; v0 = 1'b1; l0 = (idx == n - 1); acc = 1;
                end else begin
                    v0 = 1'b0; d0 = rand512(); l0 = 1'($urandom_range(0, 1));
                    if (waitc > 0) waitc--;
                end
            end else begin
                v0 = 1'($urandom_range(0, 1)); d0 = rand512(); l0 = 1'($urandom_range(0, 1));
            end
            if (acc && idx == 0) trace0.delete();
            tick();
            if (acc) begin
                cur = idx; idx++;
                if (idx < n) waitc = gapq[idx];
            end
            if (cur >= 0) lat++;
            if (cur >= 0 && busy0) chk({tag, "_core_chunk"}, core_chunk0, msgq[cur]);
            if (cur >= 0 && hash_valid0) done = 1;
        end
        v0 = 1'b0;
        chk({tag, "_done"}, done, 1'b1);
        chk({tag, "_latency"}, lat, expq.size());
        chk({tag, "_digest"}, hash_out0, ref_h);
        chk({tag, "_count"}, chunk_count0, n);
        for (int i = 0; i < expq.size(); i++)
            chk({tag, "_seq"}, (i < trace0.size()) ? trace0[i] : 3'bxxx, expq[i]);
    endtask

    initial begin
        int  lat;
        bit  found;
        reset = 1'b0;
        v0 = 1'b0; v1 = 1'b0; l0 = 1'b0; l1 = 1'b0; d0 = '0; d1 = '0;
        tick();
        tick();
        chk("rst_state", core_state0, 3'd0);
        chk("rst_ready", chunk_ready0, 1'b0);
        chk("rst_busy", busy0, 1'b0);
        chk("rst_hash", hash_out0, 256'h0);
        chk("rst_hv", hash_valid0, 1'b0);
        chk("rst_chunk", core_chunk0, 512'h0);
        chk("rst_count", chunk_count0, 16'h0);
        chk("rst_state1", core_state1, 3'd0);
        reset = 1'b1;
        tick();

        msgq = {ABC_BLK}; gapq = {0};
        run_msg("abc");
        chk("abc_kat", hash_out0, ABC_DIGEST);

        msgq = {TWO_BLK0, TWO_BLK1}; gapq = {0, 5};
        run_msg("two");
        chk("two_kat", hash_out0, TWO_DIGEST);

        // Accepted in the hash_valid cycle of the previous message.
        chk("b2b_ready", chunk_ready0, 1'b1);
        msgq = {ABC_BLK}; gapq = {0};
        run_msg("b2b");
        chk("b2b_kat", hash_out0, ABC_DIGEST);

        for (int r = 0; r < 5; r++) begin
            int n;
            n = $urandom_range(1, 3);
            msgq.delete(); gapq.delete();
            for (int i = 0; i < n; i++) begin
                msgq.push_back(rand512());
                gapq.push_back((i == 0) ? 0 : $urandom_range(0, 4));
            end
            run_msg("rnd");
        end

        // SETTLE_CYCLES=3 instance.
        chk("s3_ready", chunk_ready1, 1'b1);
        d1 = ABC_BLK; v1 = 1'b1; l1 = 1'b1;
        trace1.delete();
        tick();
        v1 = 1'b0; d1 = rand512();
        lat = 1;
        for (int k = 0; k < 20 && !hash_valid1; k++) begin
            tick();
            lat++;
        end
        chk("s3_latency", lat, 9);
        chk("s3_kat", hash_out1, ABC_DIGEST);
        chk("s3_count", chunk_count1, 16'd1);
        begin
            logic [2:0] s3exp[$];
            s3exp = {3'd2, 3'd4, 3'd5, 3'd3, 3'd3, 3'd3, 3'd6, 3'd7, 3'd0};
            for (int i = 0; i < s3exp.size(); i++)
                chk("s3_seq", (i < trace1.size()) ? trace1[i] : 3'bxxx, s3exp[i]);
        end

        // Reset during COMP of the first chunk of a two-chunk message.
        tick();
        d0 = TWO_BLK0; v0 = 1'b1; l0 = 1'b0;
        tick();
        v0 = 1'b0;
        found = 0;
        for (int k = 0; k < 10; k++) begin
            if (core_state0 == 3'd5) begin
                found = 1;
                break;
            end
            tick();
        end
        chk("mid_reach_comp", found, 1'b1);
        reset = 1'b0;
        tick();
        chk("mid_state", core_state0, 3'd0);
        chk("mid_busy", busy0, 1'b0);
        chk("mid_hash", hash_out0, 256'h0);
        chk("mid_count", chunk_count0, 16'h0);
        chk("mid_chunk", core_chunk0, 512'h0);
        reset = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("mid_no_hv", hash_valid0, 1'b0);
        end
        msgq = {ABC_BLK}; gapq = {0};
        run_msg("post_rst");
        chk("post_rst_kat", hash_out0, ABC_DIGEST);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sha256_sequencer.md
Name: sha256_sequencer

Overview:
- Control FSM that drives the 3-bit `state` bus and the 512-bit `chunk` bus of the SHA-256 core. It accepts a message as a stream of pre-padded 512-bit chunks over a valid/ready handshake.
- Sequence per message: hash init, then load/compress for each chunk, then final hash publish.
- The result is captured into a local register and announced with a one-cycle valid pulse.
- Sits between the mining front-end (header/nonce builder) and the SHA-256 core instance.

Parameters:
- SETTLE_CYCLES, 0, extra idle cycles (core state 3) inserted after each compress cycle; multicycle-path margin for the compress loop.
- CNT_W, 16, width of the chunk counter.

Ports:
- clock  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-low reset.
- chunk_data  in  512  pre-padded message chunk, MSB = first message bit.
- chunk_valid  in  1  chunk_data/chunk_last valid.
- chunk_last  in  1  marks the final chunk of the message.
- chunk_ready  out  1  sequencer can accept a chunk this cycle.
- core_state  out  3  drives the core's state input.
- core_chunk  out  512  drives the core's chunk input (registered copy of the accepted chunk).
- core_hash  in  256  core HASH output.
- hash_out  out  256  captured digest, held until the next message completes.
- hash_valid  out  1  one-cycle pulse: hash_out updated.
- busy  out  1  message in progress (FSM not IDLE).
- chunk_count  out  CNT_W  chunks compressed in the current/last message; wraps modulo 2^CNT_W.

Behaviour:
- Reset (reset=0 at posedge):
  - FSM goes to IDLE; core_state=0; chunk_ready=0 (gated by reset); busy=0.
  - hash_out=0, hash_valid=0, core_chunk=0, chunk_count=0.
  - Reset mid-message abandons the message with no hash_valid; the core is reset by the same signal.
- States and the core_state each one drives (Moore; core_state is registered, so it changes only on clock edges):
  - IDLE (0): chunk_ready=1. On chunk_valid: latch core_chunk and last_flag, clear chunk_count, go to INIT.
  - INIT (2): one cycle, then LOAD.
  - LOAD (4): one cycle; core_chunk is stable. Then COMP.
  - COMP (5): exactly one cycle, never repeated for the same chunk. chunk_count+1. Then SETTLE if SETTLE_CYCLES>0. Otherwise FINAL if last_flag, else WAIT.
  - SETTLE (3): SETTLE_CYCLES cycles, counted by a down-counter. Then FINAL or WAIT, same rule as COMP.
  - WAIT (3): chunk_ready=1. On chunk_valid: latch chunk and last_flag, go to LOAD; INIT is skipped, so the core chains state.
  - FINAL (6): one cycle; core updates HASH at the closing edge.
  - CAPT (7): one cycle. At the closing edge hash_out<=core_hash and hash_valid<=1; go to IDLE.
- A handshake occurs only when chunk_valid && chunk_ready at a posedge. chunk_valid in any other state is ignored and does not need to be held stable.
- hash_valid is high exactly during the first IDLE cycle after CAPT. A new chunk accepted in that cycle is legal (back-to-back messages).
- Latency with SETTLE_CYCLES=0:
  - Single chunk: accept edge to hash_valid high = 6 cycles.
  - Each additional chunk adds 2 cycles plus the WAIT time.
  - Each chunk adds SETTLE_CYCLES.
- busy=1 in all states except IDLE.
- chunk_ready depends only on FSM state and reset, never on chunk_valid.
- Undefined FSM encodings recover to IDLE.

Decomposition:
- Shared package sha_pkg: core state encodings (ST_IDLE=0, ST_INIT=2, ST_GAP=3, ST_LOAD=4, ST_COMP=5, ST_FINAL=6, ST_CAPT=7) and the chunk/hash width constants. The SHA core's case labels use the same package.
- No sub-module: a single FSM plus counters and registers. The bench instantiates sha256_sequencer together with SHA_256.

Test Plan:
- Single chunk "abc" (chunk 0x61626380_0…0_00000018), chunk_last=1:
  - Core sequence must be 0,2,4,5,6,7,0.
  - hash_out=ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
  - hash_valid high for 1 cycle, 6 cycles after accept; chunk_count=1.
- Two-chunk "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq":
  - chunk_valid for chunk 2 withheld 5 cycles in WAIT; core state holds 3 with no INIT before LOAD.
  - hash_out=248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1; chunk_count=2.
- SETTLE_CYCLES=3 rerun of "abc": three core_state=3 cycles between 5 and 6; same digest; latency 9 cycles.
- chunk_valid asserted during INIT/LOAD/COMP/FINAL: not accepted, chunk_ready=0 and core_chunk unchanged. Back-to-back message accepted in the hash_valid cycle produces the correct second digest.
- reset=0 for one cycle during COMP of chunk 1 of a 2-chunk message: next cycle core_state=0, busy=0, hash_valid never pulses, hash_out=0. A subsequent "abc" message yields the correct digest.
